// File: rtl/decoder_rr_arbiter.sv
// Four-requester round-robin arbiter with a registered index plus one-hot decoded grant,
// a hold/release handshake, an optional max-hold timeout and rotating priority.
module decoder_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout,
    output logic       dbg_state,
    output logic [1:0] dbg_ptr
);

    // Handshake: requester i raises req[i] and keeps it high while it wants the slot; it owns
    // the slot while gnt[i]=1 and releases it by dropping req[i]. A grant is revoked when enable
    // falls or the hold limit is reached; every grant is followed by one idle cycle with gnt=0.

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_SAT  = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : HOLD_LIM;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state;
    state_e           state_nxt;
    logic [1:0]       ptr;
    logic [1:0]       ptr_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       idx_nxt;
    logic             valid_nxt;
    logic             timeout_nxt;
    logic [3:0]       gnt_nxt;

    logic             pick_found;
    logic [1:0]       pick_idx;
    logic             holder_req;
    logic             hold_expired;
    logic             revoke;

    function automatic logic [3:0] dec2to4(input logic en, input logic [1:0] sel);
        logic [3:0] onehot;
        onehot = 4'b0000;
        if (en) begin
            case (sel)
                2'd0:    onehot = 4'b0001;
                2'd1:    onehot = 4'b0010;
                2'd2:    onehot = 4'b0100;
                default: onehot = 4'b1000;
            endcase
        end
        return onehot;
    endfunction

    // Walk offsets from the far end so the lowest offset from ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                pick_found = 1'b1;
                pick_idx   = ptr + 2'(k);
            end
        end
    end

    always_comb begin
        holder_req   = req[gnt_idx];
        hold_expired = (MAX_HOLD != 0) && (cnt == HOLD_LIM);
        revoke       = !holder_req || !enable || hold_expired;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && pick_found) state_nxt = GRANT;
            GRANT:   if (revoke) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Release outranks enable, which outranks the hold limit; only the last raises timeout.
    always_comb begin
        idx_nxt     = gnt_idx;
        valid_nxt   = 1'b0;
        timeout_nxt = 1'b0;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        case (state)
            IDLE: begin
                if (enable && pick_found) begin
                    idx_nxt   = pick_idx;
                    valid_nxt = 1'b1;
                    cnt_nxt   = CNT_ONE;
                end
            end
            GRANT: begin
                if (revoke) begin
                    ptr_nxt     = gnt_idx + 2'd1;
                    cnt_nxt     = '0;
                    timeout_nxt = holder_req && enable && hold_expired;
                end else begin
                    valid_nxt = 1'b1;
                    cnt_nxt   = (cnt == CNT_SAT) ? cnt : cnt + CNT_ONE;
                end
            end
            default: begin
                valid_nxt = 1'b0;
            end
        endcase
        gnt_nxt = dec2to4(valid_nxt, idx_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= 4'b0000;
            gnt_idx   <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= 2'd0;
            cnt       <= '0;
        end else begin
            gnt       <= gnt_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= valid_nxt;
            timeout   <= timeout_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
        end
    end

    always_comb begin
        dbg_state = (state == GRANT);
        dbg_ptr   = ptr;
    end

`ifndef SYNTHESIS
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_gnt_decode  : assert property (@(posedge clk) disable iff (rst)
                                     gnt == dec2to4(gnt_valid, gnt_idx));
    a_timeout_idle: assert property (@(posedge clk) disable iff (rst) timeout |-> !gnt_valid);
    a_timeout_one : assert property (@(posedge clk) disable iff (rst) timeout |=> !timeout);
`endif

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter: one instance with MAX_HOLD=8, one with MAX_HOLD=0,
// checked through an expected-response queue drained by a negedge monitor.
module tb_decoder_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_a, en_b;
    logic [3:0] req_a, req_b;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] idx_a, idx_b;
    logic       valid_a, valid_b;
    logic       to_a, to_b;
    logic       st_a, st_b;
    logic [1:0] ptr_a, ptr_b;

    logic [15:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;

    decoder_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .req(req_a),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(valid_a), .timeout(to_a),
        .dbg_state(st_a), .dbg_ptr(ptr_a)
    );

    decoder_rr_arbiter #(.MAX_HOLD(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .req(req_b),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(valid_b), .timeout(to_b),
        .dbg_state(st_b), .dbg_ptr(ptr_b)
    );

    function automatic logic [7:0] ev(input logic [3:0] g, input logic [1:0] i,
                                      input logic v, input logic t);
        return {g, i, v, t};
    endfunction

    function automatic logic [3:0] oh(input logic [1:0] g);
        logic [3:0] one;
        one = 4'b0001;
        return one << g;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    endtask

    // Monitor: outputs as {gnt, gnt_idx, gnt_valid, timeout} for instance a then b.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [15:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, {16'h0, gnt_a, idx_a, valid_a, to_a, gnt_b, idx_b, valid_b, to_b},
                  {16'h0, e});
        end
    end

    task automatic step(input logic [3:0] ra, input logic ea, input logic [7:0] xa,
                        input logic [3:0] rb, input logic eb, input logic [7:0] xb,
                        input string nm);
        req_a = ra;
        en_a  = ea;
        req_b = rb;
        en_b  = eb;
        @(posedge clk);
        #1;
        exp_q.push_back({xa, xb});
        name_q.push_back(nm);
    endtask

    task automatic step_a(input logic [3:0] r, input logic e, input logic [7:0] x,
                          input string nm);
        step(r, e, x, 4'b0000, 1'b0, ev(4'b0000, 2'd0, 1'b0, 1'b0), nm);
    endtask

    task automatic step_b(input logic [3:0] r, input logic e, input logic [7:0] x,
                          input string nm);
        step(4'b0000, 1'b0, ev(4'b0000, 2'd0, 1'b0, 1'b0), r, e, x, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] seq [5];
        seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst   = 1'b1;
        req_a = 4'b0000;
        req_b = 4'b0000;
        en_a  = 1'b0;
        en_b  = 1'b0;
        #2;
        check("reset_outputs_a", {gnt_a, idx_a, valid_a, to_a}, 8'h00);
        check("reset_outputs_b", {gnt_b, idx_b, valid_b, to_b}, 8'h00);
        check("reset_state_ptr", {st_a, ptr_a}, 3'b000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int c = 0; c < 5; c++)
            step_a(4'b0000, 1'b1, ev(4'b0000, 2'd0, 1'b0, 1'b0), "idle_no_req");

        step_a(4'b1010, 1'b1, ev(4'b0010, 2'd1, 1'b1, 1'b0), "first_grant");
        step_a(4'b1010, 1'b1, ev(4'b0010, 2'd1, 1'b1, 1'b0), "hold_grant");
        step_a(4'b1000, 1'b1, ev(4'b0000, 2'd1, 1'b0, 1'b0), "release_gap");
        step_a(4'b1010, 1'b1, ev(4'b1000, 2'd3, 1'b1, 1'b0), "rotate_to_3");
        step_a(4'b0000, 1'b1, ev(4'b0000, 2'd3, 1'b0, 1'b0), "release_3");
        check("ptr_after_release_3", ptr_a, 2'd0);
        step_a(4'b0000, 1'b1, ev(4'b0000, 2'd3, 1'b0, 1'b0), "idle_keep_idx");

        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 8; c++)
                step_a(4'b1111, 1'b1, ev(oh(seq[p]), seq[p], 1'b1, 1'b0), "rr_hold");
            step_a(4'b1111, 1'b1, ev(4'b0000, seq[p], 1'b0, 1'b1), "rr_timeout");
        end
        step_a(4'b0000, 1'b1, ev(4'b0000, 2'd0, 1'b0, 1'b0), "rr_drop");
        check("ptr_after_rr", ptr_a, 2'd1);

        step_a(4'b0100, 1'b1, ev(4'b0100, 2'd2, 1'b1, 1'b0), "grant_2");
        for (int c = 0; c < 7; c++)
            step_a(4'b0100, 1'b1, ev(4'b0100, 2'd2, 1'b1, 1'b0), "hold_2");
        step_a(4'b0000, 1'b1, ev(4'b0000, 2'd2, 1'b0, 1'b0), "release_at_max");
        check("ptr_after_release_at_max", ptr_a, 2'd3);

        step_a(4'b0100, 1'b1, ev(4'b0100, 2'd2, 1'b1, 1'b0), "grant_2_again");
        step_a(4'b0100, 1'b1, ev(4'b0100, 2'd2, 1'b1, 1'b0), "hold_2_again");
        step_a(4'b0100, 1'b0, ev(4'b0000, 2'd2, 1'b0, 1'b0), "enable_revoke");
        for (int c = 0; c < 3; c++)
            step_a(4'b0101, 1'b0, ev(4'b0000, 2'd2, 1'b0, 1'b0), "enable_low_no_grant");
        step_a(4'b0101, 1'b1, ev(4'b0001, 2'd0, 1'b1, 1'b0), "ptr_wrap_grant_0");
        step_a(4'b0000, 1'b1, ev(4'b0000, 2'd0, 1'b0, 1'b0), "release_0");

        step_a(4'b0001, 1'b1, ev(4'b0001, 2'd0, 1'b1, 1'b0), "pre_reset_grant");
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_gnt", {gnt_a, valid_a}, 5'b00000);
        req_a = 4'b0000;
        en_a  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("after_reset_ptr_state", {st_a, ptr_a, idx_a}, 5'b00000);

        step_a(4'b1111, 1'b1, ev(4'b0001, 2'd0, 1'b1, 1'b0), "post_reset_grant_0");
        step_a(4'b0000, 1'b1, ev(4'b0000, 2'd0, 1'b0, 1'b0), "post_reset_release");

        for (int c = 0; c < 100; c++)
            step_b(4'b0001, 1'b1, ev(4'b0001, 2'd0, 1'b1, 1'b0), "no_timeout_hold");
        step_b(4'b0000, 1'b1, ev(4'b0000, 2'd0, 1'b0, 1'b0), "no_timeout_release");

        for (int c = 0; c < 5 && exp_q.size() != 0; c++)
            @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
